// File: rtl/lcd_value_formatter.sv
// lcd_value_formatter
// Turns a 16-bit unsigned value into two 16-character ASCII lines for an LCD
// driver. Line 1 is "VAL:" followed by the decimal value, right-justified with
// leading zeros blanked. Line 2 is "HEX: 0xNNNN" when the build defines
// LCD_FMT_HEX_LINE_EN; otherwise line 2 is permanently blank and no hex logic
// is built. The binary-to-BCD conversion is a serial double-dabble, one bit
// per clock. Requests that arrive while busy are held in a one-deep pending
// slot, where a newer request replaces an older one.
module lcd_value_formatter #(
   parameter int LINE_LENGTH = 16  // only 16 is supported; the field layout is fixed
) (
   input  logic                   CLK,
   input  logic                   RESET_N,
   input  logic [15:0]            value,
   input  logic                   value_valid,
   input  logic                   sendingDone,
   output logic [8*LINE_LENGTH:1] line1,
   output logic [8*LINE_LENGTH:1] line2,
   output logic                   sendText,
   output logic                   busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      FORMAT  = 2'd2,
      SEND    = 2'd3
   } state_t;

   localparam logic [8*LINE_LENGTH:1] BLANK_LINE = {LINE_LENGTH{8'h20}};

   state_t                   state_q;
   logic [15:0]              shift_q;     // value bits still to be shifted in
   logic [19:0]              bcd_q;       // five BCD digits, digit 4 is the MSD
   logic [3:0]               cnt_q;       // CONVERT cycle index 0..15
   logic                     pend_q;
   logic [15:0]              pend_val_q;
   logic                     send_q;
   logic [8*LINE_LENGTH:1]   line1_q;

   logic [19:0]              bcd_adj;
   logic [19:0]              bcd_d;
   logic [15:0]              load_val;
   logic [8*LINE_LENGTH:1]   line1_d;

   // ASCII for one decimal digit, or a space when it is a blanked leading zero
   function automatic logic [7:0] dec_char(input logic [3:0] d, input logic blank);
      return blank ? 8'h20 : (8'h30 + {4'h0, d});
   endfunction

`ifdef LCD_FMT_HEX_LINE_EN
   logic [15:0]              value_q;     // captured value, kept for the hex line
   logic [8*LINE_LENGTH:1]   line2_q;
   logic [8*LINE_LENGTH:1]   line2_d;

   // ASCII for one uppercase hex nibble
   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   // Hex text of the captured value: "HEX: 0x" + 4 digits + 5 spaces
   always_comb begin
      line2_d = {"HEX: 0x",
                 hex_char(value_q[15:12]), hex_char(value_q[11:8]),
                 hex_char(value_q[7:4]),   hex_char(value_q[3:0]),
                 "     "};
   end
`endif

   // Double-dabble step: add 3 to every digit >= 5, then shift in the next value bit
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      bcd_adj = bcd_q;
      for (int i = 0; i < 5; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
      bcd_d = {bcd_adj[18:0], shift_q[15]};
   end

   // Decimal text: "VAL:" + 6 spaces + 5 digits with leading zeros blanked + 1 space
   always_comb begin
      logic b4, b3, b2, b1;
      b4 = (bcd_q[19:16] == 4'd0);
      b3 = b4 && (bcd_q[15:12] == 4'd0);
      b2 = b3 && (bcd_q[11:8]  == 4'd0);
      b1 = b2 && (bcd_q[7:4]   == 4'd0);
      line1_d = {"VAL:      ",
                 dec_char(bcd_q[19:16], b4), dec_char(bcd_q[15:12], b3),
                 dec_char(bcd_q[11:8],  b2), dec_char(bcd_q[7:4],   b1),
                 dec_char(bcd_q[3:0],   1'b0),
                 " "};
   end

   // Source of a new conversion: a fresh request wins over the pending slot
   always_comb begin
      load_val = value_valid ? value : pend_val_q;
   end

   // Control FSM, conversion datapath, pending slot and registered outputs
   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // right-hand side sees the pre-edge value regardless of statement order.
      if (!RESET_N) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         pend_q     <= 1'b0;
         pend_val_q <= '0;
         send_q     <= 1'b0;
         line1_q    <= BLANK_LINE;
`ifdef LCD_FMT_HEX_LINE_EN
         value_q    <= '0;
         line2_q    <= BLANK_LINE;
`endif
      end else begin
         // A request while busy goes to the pending slot; a transition below
         // that consumes it overrides this.
         if (value_valid && (state_q != IDLE)) begin
            pend_q     <= 1'b1;
            pend_val_q <= value;
         end

         case (state_q)
            IDLE: begin
               if (value_valid) begin
                  shift_q <= load_val;
                  bcd_q   <= '0;
                  cnt_q   <= '0;
`ifdef LCD_FMT_HEX_LINE_EN
                  value_q <= load_val;
`endif
                  state_q <= CONVERT;
               end
            end

            CONVERT: begin
               bcd_q   <= bcd_d;
               shift_q <= {shift_q[14:0], 1'b0};
               cnt_q   <= cnt_q + 4'd1;
               if (cnt_q == 4'd15) begin
                  state_q <= FORMAT;
               end
            end

            FORMAT: begin
               line1_q <= line1_d;
`ifdef LCD_FMT_HEX_LINE_EN
               line2_q <= line2_d;
`endif
               state_q <= SEND;
            end

            SEND: begin
               // First SEND cycle raises the request; sendingDone only counts once it is up.
               if (!send_q) begin
                  send_q <= 1'b1;
               end else if (sendingDone) begin
                  send_q <= 1'b0;
                  if (value_valid || pend_q) begin
                     pend_q  <= 1'b0;
                     shift_q <= load_val;
                     bcd_q   <= '0;
                     cnt_q   <= '0;
`ifdef LCD_FMT_HEX_LINE_EN
                     value_q <= load_val;
`endif
                     state_q <= CONVERT;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign sendText = send_q;
   assign busy     = (state_q != IDLE);
   assign line1    = line1_q;
`ifdef LCD_FMT_HEX_LINE_EN
   assign line2    = line2_q;
`else
   assign line2    = BLANK_LINE;
`endif

endmodule

// File: tb/tb_lcd_value_formatter.sv
// tb_lcd_value_formatter
// Directed bench for lcd_value_formatter: reset values, conversion latency,
// decimal/hex text for several values, the SEND handshake, pending requests
// and reset during CONVERT and SEND. Expected line2 follows LCD_FMT_HEX_LINE_EN.
module tb_lcd_value_formatter;

   localparam logic [127:0] SPACES = {16{8'h20}};

   logic         CLK;
   logic         RESET_N;
   logic [15:0]  value;
   logic         value_valid;
   logic         sendingDone;
   logic [128:1] line1;
   logic [128:1] line2;
   logic         sendText;
   logic         busy;

   int checks   = 0;
   int failures = 0;

   lcd_value_formatter #(.LINE_LENGTH(16)) dut (
      .CLK         (CLK),
      .RESET_N     (RESET_N),
      .value       (value),
      .value_valid (value_valid),
      .sendingDone (sendingDone),
      .line1       (line1),
      .line2       (line2),
      .sendText    (sendText),
      .busy        (busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Advance one clock; everything is driven and sampled 1 time unit after the edge
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected line1 for a 5-character right-justified decimal field
   function automatic logic [127:0] l1(input logic [39:0] digits);
      return {"VAL:      ", digits, " "};
   endfunction

   // Expected line2 for 4 hex characters, or blank when the hex line is not built
   function automatic logic [127:0] l2(input logic [31:0] hex);
      logic [127:0] r;
      r = {"HEX: 0x", hex, "     "};
`ifndef LCD_FMT_HEX_LINE_EN
      r = SPACES;
`endif
      return r;
   endfunction

   task automatic pulse(input logic [15:0] v);
      value       = v;
      value_valid = 1'b1;
      tick();
      value_valid = 1'b0;
   endtask

   // Wait (bounded) for sendText and check how many cycles it took
   task automatic wait_send(input string tag, input int exp_lat);
      int n;
      n = 0;
      while (!sendText && n < 40) begin
         tick();
         n++;
      end
      check({tag, " latency"}, n, exp_lat);
   endtask

   // Complete the handshake and check sendText drops on that edge
   task automatic finish_send(input string tag, input logic exp_busy);
      sendingDone = 1'b1;
      tick();
      sendingDone = 1'b0;
      check({tag, " sendText after done"}, sendText, 1'b0);
      check({tag, " busy after done"}, busy, exp_busy);
   endtask

   // Watch for n cycles and check sendText never rises
   task automatic expect_quiet(input string tag, input int n);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (sendText || busy) seen = 1'b1;
      end
      check({tag, " no activity"}, seen, 1'b0);
   endtask

   initial begin
      RESET_N     = 1'b0;
      value       = '0;
      value_valid = 1'b0;
      sendingDone = 1'b0;
      repeat (3) tick();

      // Reset values
      check("reset sendText", sendText, 1'b0);
      check("reset busy", busy, 1'b0);
      check("reset line1", line1, SPACES);
      check("reset line2", line2, SPACES);
      RESET_N = 1'b1;
      tick();

      // sendingDone while idle is ignored
      sendingDone = 1'b1;
      repeat (4) tick();
      check("idle done busy", busy, 1'b0);
      check("idle done sendText", sendText, 1'b0);
      sendingDone = 1'b0;
      tick();

      // 12345: latency 18, text, then 100 cycles without sendingDone
      pulse(16'd12345);
      check("12345 busy", busy, 1'b1);
      wait_send("12345", 18);
      check("12345 line1", line1, l1("12345"));
      check("12345 line2", line2, l2("3039"));
      for (int i = 0; i < 100; i++) begin
         tick();
         check("hold sendText", sendText, 1'b1);
         check("hold line1", line1, l1("12345"));
      end
      check("hold line2", line2, l2("3039"));
      finish_send("12345", 1'b0);

      // Boundary values
      pulse(16'd0);
      wait_send("zero", 18);
      check("zero line1", line1, l1("    0"));
      check("zero line2", line2, l2("0000"));
      finish_send("zero", 1'b0);

      pulse(16'd65535);
      wait_send("max", 18);
      check("max line1", line1, l1("65535"));
      check("max line2", line2, l2("FFFF"));
      finish_send("max", 1'b0);

      pulse(16'd1000);
      wait_send("1000", 18);
      check("1000 line1", line1, l1(" 1000"));
      check("1000 line2", line2, l2("03E8"));
      finish_send("1000", 1'b0);

      // Two requests during CONVERT: only the newer (200) is converted next
      pulse(16'd7);
      repeat (3) tick();
      pulse(16'd100);
      repeat (2) tick();
      pulse(16'd200);
      wait_send("seven", 11);
      check("seven line1", line1, l1("    7"));
      finish_send("seven", 1'b1);
      wait_send("pend200", 18);
      check("pend200 line1", line1, l1("  200"));
      check("pend200 line2", line2, l2("00C8"));
      finish_send("pend200", 1'b0);
      expect_quiet("after pend200", 40);

      // Request on the same edge SEND exits becomes the next conversion
      pulse(16'd3000);
      wait_send("3000", 18);
      check("3000 line1", line1, l1(" 3000"));
      value       = 16'd55;
      value_valid = 1'b1;
      sendingDone = 1'b1;
      tick();
      value_valid = 1'b0;
      sendingDone = 1'b0;
      check("exit-edge sendText", sendText, 1'b0);
      check("exit-edge busy", busy, 1'b1);
      wait_send("55", 18);
      check("55 line1", line1, l1("   55"));
      finish_send("55", 1'b0);

      // Reset around CONVERT cycle 8 with a pending request loaded
      pulse(16'd999);
      repeat (2) tick();
      pulse(16'd888);
      repeat (5) tick();
      RESET_N = 1'b0;
      tick();
      check("midconv sendText", sendText, 1'b0);
      check("midconv busy", busy, 1'b0);
      check("midconv line1", line1, SPACES);
      check("midconv line2", line2, SPACES);
      RESET_N = 1'b1;
      expect_quiet("after midconv reset", 40);

      // 4660 = 0x1234, then reset while in SEND
      pulse(16'd4660);
      wait_send("4660", 18);
      check("4660 line1", line1, l1(" 4660"));
      check("4660 line2", line2, l2("1234"));
      RESET_N = 1'b0;
      tick();
      check("send reset sendText", sendText, 1'b0);
      check("send reset busy", busy, 1'b0);
      check("send reset line1", line1, SPACES);
      check("send reset line2", line2, SPACES);
      RESET_N = 1'b1;
      expect_quiet("after send reset", 20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
